vga_timing_gen: RTL

Generates 640x480 @ 60 Hz VGA raster timing from the 100 MHz board clock. It produces the `hCount`/`vCount`/`bright` scan coordinates consumed by the game/pixel logic. It also samples the 12-bit colour returned by that logic and drives the registered, sync-aligned VGA pins. A once-per-frame strobe paces game-state updates.

---
 rtl/vga_timing_gen.sv | 83 ++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel-rate counters, blanking and registered sync/colour pins.
// Pins lag the presented hCount/vCount by one pixel period; there is no backpressure because the raster is free-running.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        frame_tick,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  vgaR,
  output logic [3:0]  vgaG,
  output logic [3:0]  vgaB
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_LO = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_VIS_HI = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [9:0] V_VIS_LO = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_VIS_HI = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);

  logic [DIV_W-1:0] div;

  assign pix_en     = (div == DIV_LAST);
  assign frame_tick = pix_en && (hCount == H_LAST) && (vCount == V_LAST);
  assign bright     = (hCount >= H_VIS_LO) && (hCount <= H_VIS_HI) &&
                      (vCount >= V_VIS_LO) && (vCount <= V_VIS_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div    <= '0;
      hCount <= '0;
      vCount <= '0;
    end else begin
      div <= pix_en ? '0 : div + 1'b1;
      if (pix_en) begin
        if (hCount == H_LAST) begin
          hCount <= '0;
          vCount <= (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
        end else begin
          hCount <= hCount + 10'd1;
        end
      end
    end
  end

  // Sync and colour are captured together so they leave with identical delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hSync <= 1'b1;
      vSync <= 1'b1;
      vgaR  <= '0;
      vgaG  <= '0;
      vgaB  <= '0;
    end else if (pix_en) begin
      hSync              <= ~(hCount < H_SYNC_W);
      vSync              <= ~(vCount < V_SYNC_W);
      {vgaR, vgaG, vgaB} <= bright ? rgb : 12'h000;
    end
  end

endmodule
